adc_scan_sched: RTL and testbench

Channel scan scheduler for the MAX10 modular ADC command/response interface in `adc_qsys`. It replaces the tied-high "always valid, switch-selected channel" command drive. It walks a mask of enabled analog inputs in ascending order, issuing one conversion command at a time and matching each response to its request. It emits tagged samples, scan-complete pulses and sticky error flags for downstream voltage scaling and display logic. It sits in the `sys_clk` domain, between the ADC core and the sample consumers.

---
 rtl/adc_sched_pkg.sv | 16 +
 rtl/adc_chan_pick.sv | 25 ++
 rtl/adc_scan_sched.sv | 168 ++++++++++++++++
 tb/tb_adc_scan_sched.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_sched_pkg.sv
// Shared types and constants for the ADC channel scan scheduler.
package adc_sched_pkg;

  localparam int unsigned NUM_CH    = 8;
  localparam int unsigned DATA_W    = 12;
  localparam int unsigned CH_OFFSET = 1;
  localparam int unsigned ADC_CH_W  = 5;

  typedef enum logic [1:0] {
    StIdle,
    StSelect,
    StIssue,
    StWaitRsp
  } state_e;

endpackage

// File: rtl/adc_chan_pick.sv
// Finds the lowest enabled channel at or above ptr and flags whether it is the
// highest enabled channel in the mask.
module adc_chan_pick #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned IDX_W  = 3
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  cur,
  output logic              last
);

  always_comb begin
    cur  = '0;
    last = 1'b1;
    // Descending walk so the lowest qualifying bit is the one left standing.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (IDX_W'(i) >= ptr)) cur = IDX_W'(i);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (mask[i] && (IDX_W'(i) > cur)) last = 1'b0;
    end
  end

endmodule

// File: rtl/adc_scan_sched.sv
// Channel scan scheduler for the modular ADC command/response interface: walks
// the enabled-channel mask, one conversion at a time, and tags the returned samples.
module adc_scan_sched #(
  parameter int unsigned NUM_CH  = adc_sched_pkg::NUM_CH,
  parameter int unsigned DATA_W  = adc_sched_pkg::DATA_W,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                              sys_clk,
  input  logic                              reset,
  input  logic [NUM_CH-1:0]                 cfg_chan_en,
  input  logic                              cfg_continuous,
  input  logic                              start,
  input  logic                              stop,
  output logic                              cmd_valid,
  output logic [adc_sched_pkg::ADC_CH_W-1:0] cmd_channel,
  output logic                              cmd_sop,
  output logic                              cmd_eop,
  input  logic                              cmd_ready,
  input  logic                              rsp_valid,
  input  logic [adc_sched_pkg::ADC_CH_W-1:0] rsp_channel,
  input  logic [DATA_W-1:0]                 rsp_data,
  output logic                              smp_valid,
  output logic [$clog2(NUM_CH)-1:0]         smp_index,
  output logic [DATA_W-1:0]                 smp_data,
  output logic                              scan_done,
  output logic                              busy,
  output logic                              err_timeout,
  output logic                              err_mismatch,
  input  logic                              err_clear
);
  import adc_sched_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_CH);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    cur_q, cur_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                stop_pend_q, stop_pend_d;
  logic                smp_valid_d, scan_done_d, err_timeout_d, err_mismatch_d;
  logic [IDX_W-1:0]    smp_index_d;
  logic [DATA_W-1:0]   smp_data_d;
  logic [IDX_W-1:0]    pick_cur;
  logic                pick_last;
  logic [ADC_CH_W-1:0] cur_chan;
  logic                done;

  adc_chan_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_pick (
    .mask (mask_q),
    .ptr  (ptr_q),
    .cur  (pick_cur),
    .last (pick_last)
  );

  assign cur_chan    = ADC_CH_W'(cur_q) + ADC_CH_W'(CH_OFFSET);
  assign cmd_valid   = (state_q == StIssue);
  assign cmd_channel = cmd_valid ? cur_chan : '0;
  assign cmd_sop     = cmd_valid;
  assign cmd_eop     = cmd_valid;
  assign busy        = (state_q != StIdle);

  always_comb begin
    state_d        = state_q;
    mask_d         = mask_q;
    ptr_d          = ptr_q;
    cur_d          = cur_q;
    cnt_d          = cnt_q;
    stop_pend_d    = stop_pend_q | (stop && (state_q != StIdle));
    smp_valid_d    = 1'b0;
    smp_index_d    = smp_index;
    smp_data_d     = smp_data;
    scan_done_d    = 1'b0;
    err_timeout_d  = err_timeout & ~err_clear;
    err_mismatch_d = err_mismatch & ~err_clear;
    done           = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && (|cfg_chan_en)) begin
          mask_d  = cfg_chan_en;
          ptr_d   = '0;
          state_d = StSelect;
        end
      end
      StSelect: begin
        cur_d   = pick_cur;
        state_d = StIssue;
      end
      StIssue: begin
        if (cmd_ready) begin
          cnt_d   = '0;
          state_d = StWaitRsp;
        end
      end
      StWaitRsp: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (rsp_valid) begin
          done = 1'b1;
          if (rsp_channel == cur_chan) begin
            smp_valid_d = 1'b1;
            smp_index_d = cur_q;
            smp_data_d  = rsp_data;
          end else begin
            err_mismatch_d = 1'b1;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          done          = 1'b1;
          err_timeout_d = 1'b1;
        end
        // ptr_q and mask_q are frozen since SELECT, so pick_last refers to cur_q.
        if (done) begin
          scan_done_d = pick_last;
          if (stop_pend_q) begin
            state_d = StIdle;
          end else if (!pick_last) begin
            ptr_d   = cur_q + IDX_W'(1);
            state_d = StSelect;
          end else if (cfg_continuous && (|cfg_chan_en)) begin
            mask_d  = cfg_chan_en;
            ptr_d   = '0;
            state_d = StSelect;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StIdle) stop_pend_d = 1'b0;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      mask_q       <= '0;
      ptr_q        <= '0;
      cur_q        <= '0;
      cnt_q        <= '0;
      stop_pend_q  <= 1'b0;
      smp_valid    <= 1'b0;
      smp_index    <= '0;
      smp_data     <= '0;
      scan_done    <= 1'b0;
      err_timeout  <= 1'b0;
      err_mismatch <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      ptr_q        <= ptr_d;
      cur_q        <= cur_d;
      cnt_q        <= cnt_d;
      stop_pend_q  <= stop_pend_d;
      smp_valid    <= smp_valid_d;
      smp_index    <= smp_index_d;
      smp_data     <= smp_data_d;
      scan_done    <= scan_done_d;
      err_timeout  <= err_timeout_d;
      err_mismatch <= err_mismatch_d;
    end
  end

endmodule

// File: tb/tb_adc_scan_sched.sv
// Self-checking bench for adc_scan_sched: table of single scans plus hand-written
// sequences, with an ADC response model feeding a sample scoreboard.
module tb_adc_scan_sched;

  localparam int unsigned TIMEOUT = 16;

  logic        sys_clk;
  logic        reset;
  logic [7:0]  cfg_chan_en    = '0;
  logic        cfg_continuous = 1'b0;
  logic        start          = 1'b0;
  logic        stop           = 1'b0;
  logic        cmd_ready      = 1'b1;
  logic        err_clear      = 1'b0;
  logic        rsp_valid      = 1'b0;
  logic [4:0]  rsp_channel    = '0;
  logic [11:0] rsp_data       = '0;
  logic        cmd_valid, cmd_sop, cmd_eop;
  logic [4:0]  cmd_channel;
  logic        smp_valid, scan_done, busy, err_timeout, err_mismatch;
  logic [2:0]  smp_index;
  logic [11:0] smp_data;

  adc_scan_sched #(
    .NUM_CH  (8),
    .DATA_W  (12),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .sys_clk        (sys_clk),
    .reset          (reset),
    .cfg_chan_en    (cfg_chan_en),
    .cfg_continuous (cfg_continuous),
    .start          (start),
    .stop           (stop),
    .cmd_valid      (cmd_valid),
    .cmd_channel    (cmd_channel),
    .cmd_sop        (cmd_sop),
    .cmd_eop        (cmd_eop),
    .cmd_ready      (cmd_ready),
    .rsp_valid      (rsp_valid),
    .rsp_channel    (rsp_channel),
    .rsp_data       (rsp_data),
    .smp_valid      (smp_valid),
    .smp_index      (smp_index),
    .smp_data       (smp_data),
    .scan_done      (scan_done),
    .busy           (busy),
    .err_timeout    (err_timeout),
    .err_mismatch   (err_mismatch),
    .err_clear      (err_clear)
  );

  typedef struct packed {
    logic [2:0]  idx;
    logic [11:0] data;
  } smp_t;

  typedef struct {
    logic [7:0] mask;
    int         ncmd;
    int         last;
  } vec_t;

  vec_t       vecs[5];
  logic [4:0] exp_cmd[$];
  smp_t       exp_smp[$];

  int n_tests = 0, n_fail = 0;
  int n_cmd = 0, n_smp = 0, n_done = 0, last_idx = 0;
  int cyc = 0, hs_cyc = 0;
  int c0, s0, d0, t0;
  logic [4:0] bad_ch = '0, drop_ch = '0;
  logic       ignore_rsp = 1'b0;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, n_tests=%0d", n_tests);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ADC model (3-cycle latency) plus output monitor, evaluated just after each falling edge.
  task automatic adc_monitor();
    logic [4:0] pend_ch = '0;
    int         pend_cnt = 0;
    logic       match_prev = 1'b0;
    logic [7:0] seq = 8'h11;
    smp_t       e;
    forever begin
      @(negedge sys_clk);
      #1;
      if (match_prev) chk("smp_latency", 32'(smp_valid), 1);
      match_prev = 1'b0;
      rsp_valid  = 1'b0;
      if (smp_valid) begin
        n_smp++;
        last_idx = int'(smp_index);
        if (exp_smp.size() == 0) begin
          chk("smp_unexpected", 32'(smp_valid), 0);
        end else begin
          e = exp_smp.pop_front();
          chk("smp_index", 32'(smp_index), 32'(e.idx));
          chk("smp_data", 32'(smp_data), 32'(e.data));
        end
      end
      if (scan_done) begin
        n_done++;
        chk("done_with_smp", 32'(smp_valid), 1);
      end
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          rsp_valid   = 1'b1;
          rsp_channel = (pend_ch == bad_ch) ? 5'd4 : pend_ch;
          rsp_data    = {pend_ch[3:0], seq};
          seq         = seq + 8'h07;
          if ((pend_ch != bad_ch) && !ignore_rsp) begin
            exp_smp.push_back('{idx: 3'(pend_ch - 5'd1), data: rsp_data});
            match_prev = 1'b1;
          end
        end
      end
      if (cmd_valid && cmd_ready) begin
        n_cmd++;
        hs_cyc = cyc + 1;
        if (exp_cmd.size() == 0) chk("cmd_unexpected", 32'(cmd_valid), 0);
        else chk("cmd_channel", 32'(cmd_channel), 32'(exp_cmd.pop_front()));
        if (cmd_channel != drop_ch) begin
          pend_ch  = cmd_channel;
          pend_cnt = 3;
        end
      end
    end
  endtask

  task automatic push_mask(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) exp_cmd.push_back(5'(i + 1));
  endtask

  // Called on a falling edge; start is sampled at the next rising edge (cycle 0).
  task automatic start_scan(input logic [7:0] m);
    cfg_chan_en = m;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    chk("sel_busy", 32'(busy), 1);
    chk("sel_no_cmd", 32'(cmd_valid), 0);
    @(negedge sys_clk);
    chk("issue_cmd_valid", 32'(cmd_valid), 1);
    chk("issue_sop_eop", 32'({cmd_sop, cmd_eop}), 3);
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 400 && busy; k++) @(negedge sys_clk);
    chk(name, 32'(busy), 0);
    @(negedge sys_clk);
  endtask

  task automatic snap();
    c0 = n_cmd;
    s0 = n_smp;
    d0 = n_done;
  endtask

  initial begin
    vecs[0] = '{8'b0000_0101, 2, 2};
    vecs[1] = '{8'b1000_0000, 1, 7};
    vecs[2] = '{8'b1111_1111, 8, 7};
    vecs[3] = '{8'b0000_0001, 1, 0};
    vecs[4] = '{8'b0101_0010, 3, 6};
    reset = 1'b1;
    fork
      adc_monitor();
    join_none
    repeat (2) @(negedge sys_clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cmd", 32'({cmd_valid, cmd_sop, cmd_eop, cmd_channel}), 0);
    chk("rst_smp", 32'({smp_valid, smp_index, smp_data}), 0);
    chk("rst_flags", 32'({scan_done, err_timeout, err_mismatch}), 0);
    reset = 1'b0;
    @(negedge sys_clk);

    for (int i = 0; i < 5; i++) begin
      snap();
      push_mask(vecs[i].mask);
      start_scan(vecs[i].mask);
      wait_idle("vec_idle");
      chk("vec_ncmd", 32'(n_cmd - c0), 32'(vecs[i].ncmd));
      chk("vec_nsmp", 32'(n_smp - s0), 32'(vecs[i].ncmd));
      chk("vec_last_idx", 32'(last_idx), 32'(vecs[i].last));
      chk("vec_ndone", 32'(n_done - d0), 1);
      chk("vec_no_err", 32'({err_timeout, err_mismatch}), 0);
    end

    // Continuous scan with a mid-scan mask change, then stop.
    snap();
    cfg_continuous = 1'b1;
    exp_cmd.push_back(5'd8);
    exp_cmd.push_back(5'd1);
    exp_cmd.push_back(5'd2);
    exp_cmd.push_back(5'd1);
    start_scan(8'b1000_0000);
    for (int k = 0; k < 50 && n_cmd == c0; k++) @(negedge sys_clk);
    cfg_chan_en = 8'b0000_0011;
    for (int k = 0; k < 200 && (n_done - d0) < 2; k++) @(negedge sys_clk);
    stop = 1'b1;
    @(negedge sys_clk);
    stop = 1'b0;
    wait_idle("cont_stop_idle");
    cfg_continuous = 1'b0;
    chk("cont_ncmd", 32'(n_cmd - c0), 4);
    chk("cont_ndone", 32'(n_done - d0), 2);
    chk("cont_nsmp", 32'(n_smp - s0), 4);

    // cmd_ready held low for 5 cycles in ISSUE.
    snap();
    cmd_ready = 1'b0;
    push_mask(8'b0000_0010);
    start_scan(8'b0000_0010);
    for (int j = 0; j < 5; j++) begin
      chk("stall_valid", 32'(cmd_valid), 1);
      chk("stall_channel", 32'(cmd_channel), 2);
      @(negedge sys_clk);
    end
    cmd_ready = 1'b1;
    chk("stall_valid_last", 32'(cmd_valid), 1);
    chk("stall_channel_last", 32'(cmd_channel), 2);
    wait_idle("stall_idle");
    chk("stall_ncmd", 32'(n_cmd - c0), 1);

    // Wrong response channel on channel 2.
    snap();
    bad_ch = 5'd2;
    push_mask(8'b0000_0110);
    start_scan(8'b0000_0110);
    wait_idle("mis_idle");
    bad_ch = '0;
    chk("mis_flag", 32'(err_mismatch), 1);
    chk("mis_no_timeout", 32'(err_timeout), 0);
    chk("mis_nsmp", 32'(n_smp - s0), 1);
    chk("mis_ncmd", 32'(n_cmd - c0), 2);
    err_clear = 1'b1;
    @(negedge sys_clk);
    err_clear = 1'b0;
    chk("mis_cleared", 32'(err_mismatch), 0);

    // No response on channel 1.
    snap();
    drop_ch = 5'd1;
    push_mask(8'b0000_0011);
    start_scan(8'b0000_0011);
    for (int k = 0; k < 100 && !err_timeout; k++) @(negedge sys_clk);
    chk("to_delay", 32'(cyc - hs_cyc), 16);
    t0 = cyc;
    for (int k = 0; k < 20 && !cmd_valid; k++) @(negedge sys_clk);
    chk("to_next_cmd", 32'(cyc - t0), 1);
    chk("to_next_channel", 32'(cmd_channel), 2);
    wait_idle("to_idle");
    drop_ch = '0;
    chk("to_nsmp", 32'(n_smp - s0), 1);
    chk("to_ndone", 32'(n_done - d0), 1);
    chk("to_no_mismatch", 32'(err_mismatch), 0);
    err_clear = 1'b1;
    @(negedge sys_clk);
    err_clear = 1'b0;
    chk("to_cleared", 32'(err_timeout), 0);

    // Zero-mask start is ignored.
    cfg_chan_en = '0;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    chk("zero_busy", 32'(busy), 0);
    @(negedge sys_clk);
    chk("zero_no_cmd", 32'({busy, cmd_valid}), 0);

    // Reset during WAIT_RSP; the late response lands in IDLE.
    snap();
    ignore_rsp = 1'b1;
    push_mask(8'b0000_0001);
    start_scan(8'b0000_0001);
    @(negedge sys_clk);
    chk("rw_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    chk("rw_busy_async", 32'(busy), 0);
    chk("rw_cmd", 32'({cmd_valid, cmd_channel}), 0);
    chk("rw_smp", 32'({smp_valid, smp_index, smp_data}), 0);
    chk("rw_flags", 32'({scan_done, err_timeout, err_mismatch}), 0);
    @(negedge sys_clk);
    reset = 1'b0;
    repeat (6) @(negedge sys_clk);
    ignore_rsp = 1'b0;
    chk("late_rsp_busy", 32'(busy), 0);
    chk("late_rsp_nsmp", 32'(n_smp - s0), 0);
    chk("late_rsp_flags", 32'({err_timeout, err_mismatch}), 0);

    chk("cmd_queue_empty", 32'(exp_cmd.size()), 0);
    chk("smp_queue_empty", 32'(exp_smp.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
